// File: rtl/mem_controller_if.sv
// Requester-side bundle of the memory controller: instruction-fetch port and load/store port.
// master = requesters (fetcher + LSB), slave = mem_controller.
interface mem_controller_if #(
  parameter int unsigned XLEN = 32
);
  logic            icache_req;
  logic [XLEN-1:0] icache_addr;
  logic            mc_icache_ready;
  logic [XLEN-1:0] mc_icache_inst;

  logic            lsb_req;
  logic            lsb_we;
  logic [XLEN-1:0] lsb_addr;
  logic [1:0]      lsb_size;
  logic [XLEN-1:0] lsb_wdata;
  logic            mc_lsb_ready;
  logic [XLEN-1:0] mc_lsb_rdata;

  modport master (
    output icache_req, icache_addr, lsb_req, lsb_we, lsb_addr, lsb_size, lsb_wdata,
    input  mc_icache_ready, mc_icache_inst, mc_lsb_ready, mc_lsb_rdata
  );

  modport slave (
    input  icache_req, icache_addr, lsb_req, lsb_we, lsb_addr, lsb_size, lsb_wdata,
    output mc_icache_ready, mc_icache_inst, mc_lsb_ready, mc_lsb_rdata
  );
endinterface

// File: rtl/mem_controller.sv
// Shares the byte-wide RAM/IO port between instruction fetch and the load/store buffer,
// serialising multi-byte accesses and assembling read data little-endian.
module mem_controller #(
  parameter int unsigned XLEN       = 32,
  parameter logic [1:0]  IO_ADDR_HI = 2'b11
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            rdy,
  input  logic            flush,
  input  logic            io_buffer_full,
  input  logic [7:0]      mem_din,
  output logic [7:0]      mem_dout,
  output logic [XLEN-1:0] mem_a,
  output logic            mem_wr,
  mem_controller_if.slave bus
);

  localparam int NumBytes = XLEN / 8;
  localparam logic [XLEN-1:0] One = {{(XLEN-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {StIdle, StRead, StWrite} state_e;
  typedef enum logic {OwnIcache, OwnLsb} owner_e;

  state_e          state_q, state_d;
  owner_e          owner_q, owner_d, last_q, last_d;
  logic [2:0]      cnt_q, cnt_d, len_q, len_d;
  logic [XLEN-1:0] wdata_q, wdata_d, buf_q, buf_d;
  logic            io_q, io_d;
  logic [XLEN-1:0] mem_a_q, mem_a_d;
  logic [7:0]      mem_dout_q, mem_dout_d;
  logic            mem_wr_q, mem_wr_d;
  logic            ic_ready_q, ic_ready_d, lsb_ready_q, lsb_ready_d;
  logic [XLEN-1:0] ic_inst_q, ic_inst_d, lsb_rdata_q, lsb_rdata_d;

  logic       ic_ok, ld_ok, st_ok, lsb_io, grant_ic, grant_lsb;
  logic [2:0] lsb_len;
  logic [7:0] wbyte;

  assign lsb_io = (bus.lsb_addr[17:16] == IO_ADDR_HI);
  assign ic_ok  = bus.icache_req && !ic_ready_q && !flush;
  assign ld_ok  = bus.lsb_req && !bus.lsb_we && !lsb_ready_q && !flush;
  // Stores are already committed, so they ignore flush.
  assign st_ok  = bus.lsb_req && bus.lsb_we && !lsb_ready_q && !(lsb_io && io_buffer_full);

  always_comb begin
    case (bus.lsb_size)
      2'd0:    lsb_len = 3'd1;
      2'd1:    lsb_len = 3'd2;
      default: lsb_len = 3'd4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    len_d       = len_q;
    wdata_d     = wdata_q;
    io_d        = io_q;
    buf_d       = buf_q;
    mem_a_d     = mem_a_q;
    mem_dout_d  = mem_dout_q;
    mem_wr_d    = mem_wr_q;
    ic_ready_d  = 1'b0;
    lsb_ready_d = 1'b0;
    ic_inst_d   = ic_inst_q;
    lsb_rdata_d = lsb_rdata_q;
    grant_lsb   = 1'b0;
    grant_ic    = 1'b0;
    wbyte       = wdata_q[7:0];
    for (int i = 0; i < NumBytes; i++) begin
      if (cnt_q == 3'(i)) wbyte = wdata_q[8*i +: 8];
    end

    unique case (state_q)
      StIdle: begin
        mem_wr_d  = 1'b0;
        grant_lsb = (ld_ok || st_ok) && (!ic_ok || last_q == OwnIcache);
        grant_ic  = ic_ok && !grant_lsb;
        if (grant_ic) begin
          state_d = StRead;
          owner_d = OwnIcache;
          last_d  = OwnIcache;
          mem_a_d = bus.icache_addr;
          cnt_d   = 3'd0;
          len_d   = 3'd4;
          buf_d   = '0;
        end else if (grant_lsb) begin
          owner_d = OwnLsb;
          last_d  = OwnLsb;
          mem_a_d = bus.lsb_addr;
          len_d   = lsb_len;
          buf_d   = '0;
          if (st_ok) begin
            state_d    = StWrite;
            wdata_d    = bus.lsb_wdata;
            io_d       = lsb_io;
            mem_dout_d = bus.lsb_wdata[7:0];
            mem_wr_d   = 1'b1;
            cnt_d      = 3'd1;
          end else begin
            state_d = StRead;
            cnt_d   = 3'd0;
          end
        end
      end

      StRead: begin
        if (flush) begin
          state_d  = StIdle;
          mem_wr_d = 1'b0;
        end else begin
          // RAM data lags the presented address by one cycle, so byte i lands at count i+1.
          for (int i = 0; i < NumBytes; i++) begin
            if (cnt_q == 3'(i + 1)) buf_d[8*i +: 8] = mem_din;
          end
          if (cnt_q < len_q - 3'd1) mem_a_d = mem_a_q + One;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == len_q) begin
            state_d = StIdle;
            if (owner_q == OwnIcache) begin
              ic_ready_d = 1'b1;
              ic_inst_d  = buf_d;
            end else begin
              lsb_ready_d = 1'b1;
              lsb_rdata_d = buf_d;
            end
          end
        end
      end

      StWrite: begin
        if (cnt_q == len_q) begin
          state_d     = StIdle;
          mem_wr_d    = 1'b0;
          lsb_ready_d = 1'b1;
        end else if (io_q && io_buffer_full) begin
          mem_wr_d = 1'b0;
        end else begin
          mem_a_d    = mem_a_q + One;
          mem_dout_d = wbyte;
          mem_wr_d   = 1'b1;
          cnt_d      = cnt_q + 3'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      owner_q     <= OwnIcache;
      last_q      <= OwnIcache;
      cnt_q       <= 3'd0;
      len_q       <= 3'd0;
      wdata_q     <= '0;
      io_q        <= 1'b0;
      buf_q       <= '0;
      mem_a_q     <= '0;
      mem_dout_q  <= 8'h00;
      mem_wr_q    <= 1'b0;
      ic_ready_q  <= 1'b0;
      lsb_ready_q <= 1'b0;
      ic_inst_q   <= '0;
      lsb_rdata_q <= '0;
    end else if (rdy) begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      wdata_q     <= wdata_d;
      io_q        <= io_d;
      buf_q       <= buf_d;
      mem_a_q     <= mem_a_d;
      mem_dout_q  <= mem_dout_d;
      mem_wr_q    <= mem_wr_d;
      ic_ready_q  <= ic_ready_d;
      lsb_ready_q <= lsb_ready_d;
      ic_inst_q   <= ic_inst_d;
      lsb_rdata_q <= lsb_rdata_d;
    end
  end

  assign mem_a                = mem_a_q;
  assign mem_dout             = mem_dout_q;
  assign mem_wr               = mem_wr_q;
  assign bus.mc_icache_ready  = ic_ready_q;
  assign bus.mc_icache_inst   = ic_inst_q;
  assign bus.mc_lsb_ready     = lsb_ready_q;
  assign bus.mc_lsb_rdata     = lsb_rdata_q;

endmodule

// File: tb/tb_mem_controller.sv
// Bench for mem_controller: directed timing cases plus randomized traffic against a
// byte-array memory model with a separate IO-sink expectation queue.
module tb_mem_controller;

  logic        clk, rst, rdy, flush, io_buffer_full;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_controller_if #(.XLEN(32)) bus ();

  mem_controller #(.XLEN(32), .IO_ADDR_HI(2'b11)) dut (
    .clk            (clk),
    .rst            (rst),
    .rdy            (rdy),
    .flush          (flush),
    .io_buffer_full (io_buffer_full),
    .mem_din        (mem_din),
    .mem_dout       (mem_dout),
    .mem_a          (mem_a),
    .mem_wr         (mem_wr),
    .bus            (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Background RAM contents for never-written bytes.
  function automatic logic [7:0] pat(input logic [15:0] a);
    return (a[7:0] * 8'd37) ^ a[15:8] ^ 8'hA5;
  endfunction

  // RAM / IO sink seen by the DUT; frozen along with the controller when rdy is low.
  bit [7:0]   ram_ov [65536];
  bit         ram_vl [65536];
  logic       pl_en;
  logic [15:0] pl_addr;
  logic [7:0] pl_data;
  int         wr_count = 0;
  logic [7:0] io_seen [$];

  always @(posedge clk) begin
    if (pl_en) begin
      ram_ov[pl_addr] <= pl_data;
      ram_vl[pl_addr] <= 1'b1;
    end
    if (rdy) begin
      if (mem_wr) begin
        wr_count <= wr_count + 1;
        if (mem_a[17:16] == 2'b11) io_seen.push_back(mem_dout);
        else begin
          ram_ov[mem_a[15:0]] <= mem_dout;
          ram_vl[mem_a[15:0]] <= 1'b1;
        end
      end
      mem_din <= ram_vl[mem_a[15:0]] ? ram_ov[mem_a[15:0]] : pat(mem_a[15:0]);
    end
  end

  // Reference memory, updated only when a transaction completes.
  bit [7:0]   ref_ov [65536];
  bit         ref_vl [65536];
  logic [7:0] exp_io [$];
  byte        order_q [$];

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    logic [15:0] i;
    i = a[15:0];
    return ref_vl[i] ? ref_ov[i] : pat(i);
  endfunction

  function automatic int size_n(input logic [1:0] s);
    return (s == 2'd0) ? 1 : (s == 2'd1) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input int n);
    logic [31:0] v;
    v = 32'h0;
    for (int i = 0; i < n; i++) v = v | (32'(ref_rd(a + 32'(i))) << (8 * i));
    return v;
  endfunction

  task automatic ref_store(input logic [31:0] a, input int n, input logic [31:0] d);
    logic [31:0] ai;
    for (int i = 0; i < n; i++) begin
      ai = a + 32'(i);
      if (a[17:16] == 2'b11) exp_io.push_back(8'(d >> (8 * i)));
      else begin
        ref_ov[ai[15:0]] = 8'(d >> (8 * i));
        ref_vl[ai[15:0]] = 1'b1;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [15:0] a, input logic [7:0] d);
    pl_en   = 1'b1;
    pl_addr = a;
    pl_data = d;
    ref_ov[a] = d;
    ref_vl[a] = 1'b1;
    tick();
    pl_en = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic ic_txn(input logic [31:0] a, output int lat);
    bit got;
    int guard;
    got = 0;
    lat = 0;
    bus.icache_req  = 1'b1;
    bus.icache_addr = a;
    while (!got && lat < 300) begin
      tick();
      lat++;
      if (bus.mc_icache_ready) got = 1;
    end
    bus.icache_req = 1'b0;
    check("ic_done", 32'(got), 32'd1);
    if (got) begin
      order_q.push_back(8'h49);
      check("ic_inst", bus.mc_icache_inst, ref_load(a, 4));
    end
    guard = 0;
    while (bus.mc_icache_ready && guard < 300) begin
      tick();
      guard++;
    end
  endtask

  task automatic lsb_txn(input logic we, input logic [31:0] a, input logic [1:0] sz,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat);
    bit got;
    int guard;
    got = 0;
    lat = 0;
    bus.lsb_req   = 1'b1;
    bus.lsb_we    = we;
    bus.lsb_addr  = a;
    bus.lsb_size  = sz;
    bus.lsb_wdata = wd;
    while (!got && lat < 300) begin
      tick();
      lat++;
      if (bus.mc_lsb_ready) got = 1;
    end
    rd = bus.mc_lsb_rdata;
    bus.lsb_req = 1'b0;
    check("lsb_done", 32'(got), 32'd1);
    if (got) begin
      order_q.push_back(8'h4C);
      if (we) ref_store(a, size_n(sz), wd);
      else check("lsb_load", rd, ref_load(a, size_n(sz)));
    end
    guard = 0;
    while (bus.mc_lsb_ready && guard < 300) begin
      tick();
      guard++;
    end
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int lat, w0, io0, ic_seen, exp_wr;
    bit rnd_on;

    rst = 1'b1; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0; pl_en = 1'b0;
    pl_addr = 16'h0; pl_data = 8'h0;
    bus.icache_req = 1'b0; bus.icache_addr = 32'h0;
    bus.lsb_req = 1'b0; bus.lsb_we = 1'b0; bus.lsb_addr = 32'h0;
    bus.lsb_size = 2'd0; bus.lsb_wdata = 32'h0;
    tick();
    tick();
    preload(16'h1000, 8'h13);
    preload(16'h1001, 8'h05);
    preload(16'h1002, 8'h00);
    preload(16'h1003, 8'h00);
    preload(16'h0101, 8'h80);
    preload(16'h0102, 8'hFF);

    check("rst_mem_a", mem_a, 32'h0);
    check("rst_mem_wr", 32'(mem_wr), 32'h0);
    check("rst_mem_dout", 32'(mem_dout), 32'h0);
    check("rst_ic_ready", 32'(bus.mc_icache_ready), 32'h0);
    check("rst_lsb_ready", 32'(bus.mc_lsb_ready), 32'h0);
    check("rst_ic_inst", bus.mc_icache_inst, 32'h0);
    check("rst_lsb_rdata", bus.mc_lsb_rdata, 32'h0);
    rst = 1'b0;

    // Instruction fetch at 0x1000.
    bus.icache_req = 1'b1;
    bus.icache_addr = 32'h1000;
    tick();
    check("ic_a0", mem_a, 32'h1000);
    check("ic_rd_wr", 32'(mem_wr), 32'h0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check("ic_a_step", mem_a, 32'h1000 + 32'(i));
    end
    tick();
    check("ic_ready_early", 32'(bus.mc_icache_ready), 32'h0);
    check("ic_a_hold", mem_a, 32'h1003);
    tick();
    check("ic_ready", 32'(bus.mc_icache_ready), 32'h1);
    check("ic_inst_val", bus.mc_icache_inst, 32'h00000513);
    bus.icache_req = 1'b0;
    tick();
    check("ic_ready_pulse", 32'(bus.mc_icache_ready), 32'h0);

    // Single-byte store.
    w0 = wr_count;
    bus.lsb_req = 1'b1; bus.lsb_we = 1'b1; bus.lsb_addr = 32'h20;
    bus.lsb_size = 2'd0; bus.lsb_wdata = 32'hAABBCCDD;
    tick();
    check("st_wr", 32'(mem_wr), 32'h1);
    check("st_a", mem_a, 32'h20);
    check("st_dout", 32'(mem_dout), 32'hDD);
    tick();
    check("st_wr_end", 32'(mem_wr), 32'h0);
    check("st_ready", 32'(bus.mc_lsb_ready), 32'h1);
    bus.lsb_req = 1'b0;
    ref_store(32'h20, 1, 32'hAABBCCDD);
    tick();
    check("st_wr_idle", 32'(mem_wr), 32'h0);
    check("st_wr_cycles", 32'(wr_count - w0), 32'h1);

    // Halfword load, then a wrapping halfword load.
    lsb_txn(1'b0, 32'h101, 2'd1, 32'h0, rd, lat);
    check("ld_half_val", rd, 32'h0000FF80);
    check("ld_half_lat", 32'(lat), 32'd4);
    lsb_txn(1'b1, 32'h21, 2'd2, 32'h01020304, rd, lat);
    lsb_txn(1'b0, 32'h20, 2'd2, 32'h0, rd, lat);
    lsb_txn(1'b0, 32'hFFFFFFFF, 2'd1, 32'h0, rd, lat);

    // Both requesting continuously from reset: strict alternation, LSB first.
    do_reset();
    order_q.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) ic_txn(32'h8000 + 32'($urandom_range(0, 255)) * 2, lat);
      end
      begin
        logic [31:0] r2;
        int l2;
        for (int i = 0; i < 3; i++) lsb_txn(1'b0, 32'h9000 + $urandom_range(0, 63),
                                            2'($urandom_range(0, 2)), 32'h0, r2, l2);
      end
    join
    check("arb_count", 32'(order_q.size()), 32'd6);
    for (int i = 0; i < 6 && i < order_q.size(); i++)
      check("arb_order", 32'(order_q[i]), (i % 2 == 0) ? 32'h4C : 32'h49);

    // Flush two cycles into a fetch while a store waits.
    ic_seen = 0;
    bus.icache_req = 1'b1;
    bus.icache_addr = 32'h1000;
    tick();
    bus.lsb_req = 1'b1; bus.lsb_we = 1'b1; bus.lsb_addr = 32'h40;
    bus.lsb_size = 2'd2; bus.lsb_wdata = 32'h11223344;
    tick();
    ic_seen += 32'(bus.mc_icache_ready);
    flush = 1'b1;
    tick();
    ic_seen += 32'(bus.mc_icache_ready);
    flush = 1'b0;
    bus.icache_req = 1'b0;
    check("fl_wr_idle", 32'(mem_wr), 32'h0);
    tick();
    ic_seen += 32'(bus.mc_icache_ready);
    check("fl_st_wr", 32'(mem_wr), 32'h1);
    check("fl_st_a", mem_a, 32'h40);
    check("fl_st_dout", 32'(mem_dout), 32'h44);
    lat = 0;
    while (!bus.mc_lsb_ready && lat < 20) begin
      tick();
      ic_seen += 32'(bus.mc_icache_ready);
      lat++;
    end
    check("fl_st_ready", 32'(bus.mc_lsb_ready), 32'h1);
    bus.lsb_req = 1'b0;
    ref_store(32'h40, 4, 32'h11223344);
    tick();
    ic_seen += 32'(bus.mc_icache_ready);
    tick();
    check("fl_no_ic_ready", 32'(ic_seen), 32'h0);
    lsb_txn(1'b0, 32'h40, 2'd2, 32'h0, rd, lat);

    // IO store held while the IO buffer is full.
    io0 = io_seen.size();
    io_buffer_full = 1'b1;
    bus.lsb_req = 1'b1; bus.lsb_we = 1'b1; bus.lsb_addr = 32'h30000;
    bus.lsb_size = 2'd0; bus.lsb_wdata = 32'h0000005A;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("io_hold_wr", 32'(mem_wr), 32'h0);
    end
    io_buffer_full = 1'b0;
    tick();
    check("io_st_wr", 32'(mem_wr), 32'h1);
    check("io_st_a", mem_a, 32'h30000);
    check("io_st_dout", 32'(mem_dout), 32'h5A);
    tick();
    check("io_st_ready", 32'(bus.mc_lsb_ready), 32'h1);
    bus.lsb_req = 1'b0;
    tick();

    // IO buffer fills mid-store: next byte stalls.
    bus.lsb_req = 1'b1; bus.lsb_we = 1'b1; bus.lsb_addr = 32'h30004;
    bus.lsb_size = 2'd2; bus.lsb_wdata = 32'hCAFEF00D;
    tick();
    check("io_mid_wr0", 32'(mem_wr), 32'h1);
    io_buffer_full = 1'b1;
    tick();
    check("io_mid_stall", 32'(mem_wr), 32'h0);
    tick();
    check("io_mid_stall2", 32'(mem_wr), 32'h0);
    check("io_mid_a_hold", mem_a, 32'h30004);
    io_buffer_full = 1'b0;
    tick();
    check("io_mid_resume", 32'(mem_wr), 32'h1);
    check("io_mid_a1", mem_a, 32'h30005);
    check("io_mid_d1", 32'(mem_dout), 32'hF0);
    lat = 0;
    while (!bus.mc_lsb_ready && lat < 20) begin
      tick();
      lat++;
    end
    check("io_mid_ready", 32'(bus.mc_lsb_ready), 32'h1);
    bus.lsb_req = 1'b0;
    tick();
    check("io_byte_count", 32'(io_seen.size() - io0), 32'd5);
    if (io_seen.size() - io0 == 5) begin
      check("io_b0", 32'(io_seen[io0]), 32'h5A);
      check("io_b1", 32'(io_seen[io0 + 1]), 32'h0D);
      check("io_b4", 32'(io_seen[io0 + 4]), 32'hCA);
    end

    // rdy low mid-read freezes address and counter.
    bus.icache_req = 1'b1;
    bus.icache_addr = 32'h1000;
    tick();
    tick();
    check("frz_a1", mem_a, 32'h1001);
    rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("frz_a_hold", mem_a, 32'h1001);
      check("frz_no_ready", 32'(bus.mc_icache_ready), 32'h0);
    end
    rdy = 1'b1;
    tick();
    check("frz_a2", mem_a, 32'h1002);
    tick();
    tick();
    check("frz_ready_early", 32'(bus.mc_icache_ready), 32'h0);
    tick();
    check("frz_ready", 32'(bus.mc_icache_ready), 32'h1);
    check("frz_inst", bus.mc_icache_inst, 32'h00000513);
    bus.icache_req = 1'b0;
    tick();

    // Randomized traffic with rdy and io_buffer_full toggling.
    w0 = wr_count;
    io0 = io_seen.size();
    exp_io.delete();
    exp_wr = 0;
    rnd_on = 1;
    fork
      begin
        fork
          begin
            int l1;
            for (int i = 0; i < 25; i++) begin
              ic_txn(32'h8000 + 32'($urandom_range(0, 16'h7FF)) * 2, l1);
              repeat ($urandom_range(0, 3)) tick();
            end
          end
          begin
            logic [31:0] r2, a2, d2;
            logic [1:0] s2;
            bit we2, io2;
            int l2;
            for (int i = 0; i < 40; i++) begin
              we2 = 1'($urandom_range(0, 1));
              s2  = 2'($urandom_range(0, 2));
              io2 = we2 && ($urandom_range(0, 3) == 0);
              a2  = io2 ? 32'h30000 + $urandom_range(0, 16'hF0) : 32'h9000 + $urandom_range(0, 63);
              d2  = $urandom;
              lsb_txn(we2, a2, s2, d2, r2, l2);
              if (we2) exp_wr += size_n(s2);
              repeat ($urandom_range(0, 3)) tick();
            end
          end
        join
        rnd_on = 0;
      end
      begin
        while (rnd_on) begin
          tick();
          rdy = ($urandom_range(0, 9) != 0);
          io_buffer_full = ($urandom_range(0, 4) == 0);
        end
        rdy = 1'b1;
        io_buffer_full = 1'b0;
      end
    join
    tick();
    check("rnd_wr_count", 32'(wr_count - w0), 32'(exp_wr));
    check("rnd_io_count", 32'(io_seen.size() - io0), 32'(exp_io.size()));
    for (int i = 0; i < exp_io.size() && io0 + i < io_seen.size(); i++)
      check("rnd_io_byte", 32'(io_seen[io0 + i]), 32'(exp_io[i]));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
